lamp_stack_driver: RTL and testbench

- Upstream stage of the multi-input faulty gate: holds the lamp stack on top of one gate (INPUT_COUNT logic lamps plus one fault lamp) and drives the gate's `in` and `fault_in`.
- Each lamp toggles on wire trigger pulses.
- Emits one `eval_req` pulse per logic frame when the lamp stack changes. Later changes in the same frame are held pending and replayed after the next `logic_reset`.
- Sits between the wire-trigger router and the gate instance; its `logic_reset` input is shared with the gate.

---
 rtl/wirelog_lamp_pkg.sv | 19 +
 rtl/lamp_toggle_bank.sv | 43 ++++
 rtl/lamp_stack_driver.sv | 89 ++++++++
 tb/tb_lamp_stack_driver.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wirelog_lamp_pkg.sv
// Shared types for the lamp stack driver.
// FSM state encoding and the saturating counter helper.
package wirelog_lamp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRED = 2'd1,
        PEND  = 2'd2
    } state_e;

    // Adds one unless the value has already reached max.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic [31:0] max
    );
        return (v >= max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/lamp_toggle_bank.sv
// Logic lamps plus fault lamp with toggle, preload and async reset.
// Ports: clk_i, rst_ni, load_i, load_data_i, trig_i, fault_trig_i,
//        lamps_o, fault_o, chg_o (combinational change flag).
module lamp_toggle_bank #(
    parameter int            W    = 2,
    parameter logic [W-1:0]  INIT = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic [W-1:0] trig_i,
    input  logic         fault_trig_i,
    output logic [W-1:0] lamps_o,
    output logic         fault_o,
    output logic         chg_o
);

    logic [W-1:0] lamps_q, lamps_d;
    logic         fault_q, fault_d;

    // A load that rewrites the same value is not a change.
    always_comb begin
        lamps_d = load_i ? load_data_i : (lamps_q ^ trig_i);
        fault_d = fault_q ^ fault_trig_i;
        chg_o   = (load_i ? (load_data_i != lamps_q) : (|trig_i))
                | fault_trig_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lamps_q <= INIT;
            fault_q <= 1'b0;
        end else begin
            lamps_q <= lamps_d;
            fault_q <= fault_d;
        end
    end

    assign lamps_o = lamps_q;
    assign fault_o = fault_q;

endmodule

// File: rtl/lamp_stack_driver.sv
// Lamp stack on top of a faulty gate; one eval_req per logic frame.
// Ports: clk, reset (async low), logic_reset, trig, fault_trig, load,
//        load_data -> in, fault_in, eval_req, merged_cnt.
module lamp_stack_driver
    import wirelog_lamp_pkg::*;
#(
    parameter int                       INPUT_COUNT = 2,
    parameter logic [INPUT_COUNT-1:0]   INIT_STATE  = '0,
    parameter int                       CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   logic_reset,
    input  logic [INPUT_COUNT-1:0] trig,
    input  logic                   fault_trig,
    input  logic                   load,
    input  logic [INPUT_COUNT-1:0] load_data,
    output logic [INPUT_COUNT-1:0] in,
    output logic                   fault_in,
    output logic                   eval_req,
    output logic [CNT_WIDTH-1:0]   merged_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_e               state_q;
    logic                 eval_req_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 chg;

    lamp_toggle_bank #(
        .W    (INPUT_COUNT),
        .INIT (INIT_STATE)
    ) u_bank (
        .clk_i        (clk),
        .rst_ni       (reset),
        .load_i       (load),
        .load_data_i  (load_data),
        .trig_i       (trig),
        .fault_trig_i (fault_trig),
        .lamps_o      (in),
        .fault_o      (fault_in),
        .chg_o        (chg)
    );

    assign cnt_d = CNT_WIDTH'(sat_inc(32'(cnt_q), 32'(CNT_MAX)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            eval_req_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            eval_req_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (chg) begin
                        eval_req_q <= 1'b1;
                        state_q    <= FIRED;
                    end
                end
                FIRED: begin
                    // A change landing on logic_reset belongs
                    // to the new frame and fires at once.
                    if (logic_reset) begin
                        if (chg) eval_req_q <= 1'b1;
                        else     state_q    <= IDLE;
                    end else if (chg) begin
                        state_q <= PEND;
                        cnt_q   <= cnt_d;
                    end
                end
                PEND: begin
                    if (logic_reset) begin
                        eval_req_q <= 1'b1;
                        state_q    <= FIRED;
                    end else if (chg) begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign eval_req   = eval_req_q;
    assign merged_cnt = cnt_q;

endmodule

// File: tb/tb_lamp_stack_driver.sv
// Bench for lamp_stack_driver: vector table, hand sequences, random.
// Two instances (CNT_WIDTH 8 and 2) share every input.
module tb_lamp_stack_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       logic_reset = 1'b0;
    logic [1:0] trig = 2'b00;
    logic       fault_trig = 1'b0;
    logic       load = 1'b0;
    logic [1:0] load_data = 2'b00;

    logic [1:0] in_a, in_b;
    logic       fault_a, fault_b;
    logic       eval_a, eval_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    lamp_stack_driver u_a (
        .clk         (clk),
        .reset       (reset),
        .logic_reset (logic_reset),
        .trig        (trig),
        .fault_trig  (fault_trig),
        .load        (load),
        .load_data   (load_data),
        .in          (in_a),
        .fault_in    (fault_a),
        .eval_req    (eval_a),
        .merged_cnt  (cnt_a)
    );

    lamp_stack_driver #(.CNT_WIDTH(2)) u_b (
        .clk         (clk),
        .reset       (reset),
        .logic_reset (logic_reset),
        .trig        (trig),
        .fault_trig  (fault_trig),
        .load        (load),
        .load_data   (load_data),
        .in          (in_b),
        .fault_in    (fault_b),
        .eval_req    (eval_b),
        .merged_cnt  (cnt_b)
    );

    // Frame-level model: has a request gone out this frame,
    // and is another change waiting for the next frame.
    typedef struct {
        logic [1:0] lamps;
        logic       flt;
        logic       ev;
        bit         issued;
        bit         pending;
        int         cnt;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mreset();
        mdl_t m;
        m.lamps = 2'b00;
        m.flt = 1'b0;
        m.ev = 1'b0;
        m.issued = 1'b0;
        m.pending = 1'b0;
        m.cnt = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(
        mdl_t m, logic lr, logic [1:0] tr, logic ft,
        logic ld, logic [1:0] ldd, int cmax
    );
        mdl_t n;
        bit chg;
        n = m;
        chg = (ld ? (ldd != m.lamps) : (tr != 2'b00)) || ft;
        n.lamps = ld ? ldd : (m.lamps ^ tr);
        n.flt = m.flt ^ ft;
        n.ev = 1'b0;
        if (lr) begin
            n.ev = chg || m.pending;
            n.issued = n.ev;
            n.pending = 1'b0;
        end else if (chg && !m.issued) begin
            n.ev = 1'b1;
            n.issued = 1'b1;
        end else if (chg) begin
            n.pending = 1'b1;
            if (n.cnt < cmax) n.cnt = n.cnt + 1;
        end
        return n;
    endfunction

    typedef struct {
        logic       lr;
        logic [1:0] tr;
        logic       ft;
        logic       ld;
        logic [1:0] ldd;
        logic [1:0] ein;
        logic       ef;
        logic       ee;
        logic [7:0] ec;
    } vec_t;

    vec_t tv[16];

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    function automatic logic [31:0] pk_a();
        return {20'd0, in_a, fault_a, eval_a, cnt_a};
    endfunction

    function automatic logic [31:0] pk_b();
        return {26'd0, in_b, fault_b, eval_b, cnt_b};
    endfunction

    function automatic logic [31:0] pk_ma();
        return {20'd0, ma.lamps, ma.flt, ma.ev, ma.cnt[7:0]};
    endfunction

    function automatic logic [31:0] pk_mb();
        return {26'd0, mb.lamps, mb.flt, mb.ev, mb.cnt[1:0]};
    endfunction

    task automatic cyc(
        logic lr, logic [1:0] tr, logic ft,
        logic ld, logic [1:0] ldd
    );
        logic_reset = lr;
        trig = tr;
        fault_trig = ft;
        load = ld;
        load_data = ldd;
        @(posedge clk);
        #1;
        ma = mstep(ma, lr, tr, ft, ld, ldd, 255);
        mb = mstep(mb, lr, tr, ft, ld, ldd, 3);
    endtask

    task automatic idle();
        cyc(1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        //           lr  tr    ft  ld  ldd    in    f   e   cnt
        tv[0]  = '{1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 8'd0};
        tv[1]  = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 8'd0};
        tv[2]  = '{1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 8'd1};
        tv[3]  = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0, 8'd1};
        tv[4]  = '{1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 8'd2};
        tv[5]  = '{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 1'b1, 1'b1, 8'd2};
        tv[6]  = '{1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 8'd2};
        tv[7]  = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1, 8'd2};
        tv[8]  = '{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 8'd2};
        tv[9]  = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 8'd2};
        tv[10] = '{1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 1'b1, 1'b1, 8'd2};
        tv[11] = '{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 8'd2};
        tv[12] = '{1'b0, 2'b11, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1, 8'd2};
        tv[13] = '{1'b0, 2'b00, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 8'd2};
        tv[14] = '{1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 8'd3};
        tv[15] = '{1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1, 8'd3};

        ma = mreset();
        mb = mreset();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_a", pk_a(), 32'd0);
        chk("rst_hold_b", pk_b(), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            idle();
            chk($sformatf("rst_idle_%0d", i), pk_a(), 32'd0);
        end

        for (int i = 0; i < 16; i++) begin
            cyc(tv[i].lr, tv[i].tr, tv[i].ft, tv[i].ld, tv[i].ldd);
            chk($sformatf("vec_%0d", i), pk_a(),
                {20'd0, tv[i].ein, tv[i].ef, tv[i].ee, tv[i].ec});
        end

        // Async reset clears the counter, then saturate CNT_WIDTH=2.
        reset = 1'b0;
        #2;
        ma = mreset();
        mb = mreset();
        chk("async_rst_a", pk_a(), 32'd0);
        chk("async_rst_b", pk_b(), 32'd0);
        reset = 1'b1;

        cyc(1'b0, 2'b01, 1'b0, 1'b0, 2'b00);
        chk("sat_fire", {30'd0, eval_a, eval_b}, 32'd3);
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b0, 2'b01, 1'b0, 1'b0, 2'b00);
            chk($sformatf("sat_cnt_a_%0d", k), cnt_a, k);
            chk($sformatf("sat_cnt_b_%0d", k), cnt_b, (k > 3) ? 3 : k);
            chk($sformatf("sat_eval_%0d", k),
                {30'd0, eval_a, eval_b}, 32'd0);
        end

        // Reset while a request is pending must drop it.
        reset = 1'b0;
        #2;
        ma = mreset();
        mb = mreset();
        chk("pend_rst_a", pk_a(), 32'd0);
        chk("pend_rst_b", pk_b(), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'b00, 1'b0, 1'b0, 2'b00);
            chk($sformatf("pend_post_a_%0d", i), pk_a(), 32'd0);
            chk($sformatf("pend_post_b_%0d", i), pk_b(), 32'd0);
        end

        for (int i = 0; i < 400; i++) begin
            logic       r_lr, r_ft, r_ld;
            logic [1:0] r_tr, r_ldd;
            r_lr  = ($urandom_range(0, 3) == 0);
            r_ft  = ($urandom_range(0, 5) == 0);
            r_ld  = ($urandom_range(0, 5) == 0);
            r_tr  = ($urandom_range(0, 2) == 0) ?
                    2'($urandom_range(0, 3)) : 2'b00;
            r_ldd = 2'($urandom_range(0, 3));
            cyc(r_lr, r_tr, r_ft, r_ld, r_ldd);
            chk($sformatf("rnd_a_%0d", i), pk_a(), pk_ma());
            chk($sformatf("rnd_b_%0d", i), pk_b(), pk_mb());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
